// File: rtl/register_file.sv
// RV32I integer register file: x0..x31, one synchronous write port,
// two combinational read ports with optional write-through bypass,
// and one debug read port that always returns the stored value.
`timescale 1ns/1ps
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Register storage. Entry 0 is only ever written by reset, so it holds 0.
  logic [DATA_W-1:0] regs [DEPTH];

  // A write is committed only outside reset and never to x0.
  logic write_ok;
  assign write_ok = reg_write && (rd_addr != '0);

  // Bypass is gated by rst_n so the read ports show 0 for the whole reset.
  logic bypass_ok;
  assign bypass_ok = BYPASS && rst_n && write_ok;

  // Storage update: asynchronous clear of every entry, else the single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Both read ports share one structure; index 0 is rs1, index 1 is rs2.
  logic [ADDR_W-1:0] port_addr [2];
  logic [DATA_W-1:0] port_data [2];

  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;
  assign rs1_data     = port_data[0];
  assign rs2_data     = port_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      // Read port resolution: x0 is hard zero, then bypass, then stored value.
      always_comb begin
        port_data[gi] = regs[port_addr[gi]];
        if (port_addr[gi] == '0) begin
          port_data[gi] = '0;
        end else if (bypass_ok && (rd_addr == port_addr[gi])) begin
          port_data[gi] = rd_data;
        end
      end
    end
  endgenerate

  // Debug port sees only stored state; x0 storage is always 0.
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, reset and
// mux-integration sequences, and randomized traffic against an array model.
`timescale 1ns/1ps
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, rd_data, dbg_data;
  logic        reg_write;

  int total;
  int bad;

  logic [31:0] model [32];

  // Operand select mux sitting downstream of rs2_data.
  logic        control;
  logic [31:0] imm;
  logic [31:0] mux_out;
  assign mux_out = control ? imm : rs2_data;

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .reg_write(reg_write),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    reg_write = we;
    rd_addr   = rd;
    rd_data   = wd;
    rs1_addr  = a1;
    rs2_addr  = a2;
    dbg_addr  = ad;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, a, d, 5'd0, 5'd0, 5'd0);
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic idle();
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  ra, a1, a2, ad;
    logic [31:0] wd, e1, e2;
    logic        we;

    total = 0;
    bad   = 0;
    control = 1'b0;
    imm     = 32'd90;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Directed table: each record is checked combinationally before its edge.
    vecs[0]  = '{1'b1, 5'd5,  32'd50,        5'd0,  5'd0,  5'd5,  32'd0,         32'd0,         32'd0};
    vecs[1]  = '{1'b1, 5'd6,  32'd100,       5'd5,  5'd6,  5'd5,  32'd50,        32'd100,       32'd50};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,         5'd5,  5'd6,  5'd6,  32'd50,        32'd100,       32'd100};
    vecs[3]  = '{1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  5'd0,  5'd0,  32'd0,         32'd0,         32'd0};
    vecs[4]  = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd0,  5'd0,  32'd0,         32'd0,         32'd0};
    vecs[5]  = '{1'b1, 5'd7,  32'd90,        5'd7,  5'd5,  5'd7,  32'd90,        32'd50,        32'd0};
    vecs[6]  = '{1'b1, 5'd7,  32'd800,       5'd7,  5'd7,  5'd7,  32'd800,       32'd800,       32'd90};
    vecs[7]  = '{1'b0, 5'd0,  32'd0,         5'd7,  5'd0,  5'd7,  32'd800,       32'd0,         32'd800};
    vecs[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd30, 5'd31, 32'hFFFFFFFF,  32'd0,         32'd0};
    vecs[9]  = '{1'b1, 5'd1,  32'hA5A5A5A5,  5'd31, 5'd1,  5'd1,  32'hFFFFFFFF,  32'hA5A5A5A5,  32'd0};
    vecs[10] = '{1'b0, 5'd31, 32'd0,         5'd31, 5'd1,  5'd31, 32'hFFFFFFFF,  32'hA5A5A5A5,  32'hFFFFFFFF};

    // Power-on reset: outputs read 0 before any clock edge.
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 5'd5);
    #10;
    check("por rs1", rs1_data, 32'd0);
    check("por rs2", rs2_data, 32'd0);
    check("por dbg", dbg_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].a1, vecs[i].a2, vecs[i].ad);
      #1;
      check($sformatf("vec%0d rs1", i), rs1_data, vecs[i].e1);
      check($sformatf("vec%0d rs2", i), rs2_data, vecs[i].e2);
      check($sformatf("vec%0d dbg", i), dbg_data, vecs[i].ed);
    end
    // dbg sees the bypassed x7 write only after the edge.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'd1234, 5'd0, 5'd0, 5'd7);
    #1;
    check("dbg before edge", dbg_data, 32'd800);
    @(posedge clk);
    #1;
    check("dbg after edge", dbg_data, 32'd1234);

    // Mux integration: x3=800 on operand A, immediate 90 on operand B.
    write_reg(5'd3, 32'd800);
    idle();
    rs2_addr = 5'd3;
    control  = 1'b0;
    #1;
    check("mux ctl0", mux_out, 32'd800);
    control = 1'b1;
    #1;
    check("mux ctl1", mux_out, 32'd90);
    control = 1'b0;

    // Preload every register, then pulse reset between edges.
    for (int i = 1; i < 32; i++) write_reg(i[4:0], $urandom | 32'd1);
    idle();
    dbg_addr = 5'd17;
    #1;
    check("preload x17", dbg_data, model[17]);
    #9;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1;
      check($sformatf("rst dbg x%0d", i), dbg_data, 32'd0);
    end
    drive(1'b1, 5'd3, 32'h55AA55AA, 5'd3, 5'd3, 5'd3);
    #1;
    check("rst bypass rs1", rs1_data, 32'd0);
    check("rst bypass rs2", rs2_data, 32'd0);
    @(posedge clk);
    #1;
    check("rst write ignored", dbg_data, 32'd0);
    @(negedge clk);
    reg_write = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    check("post rst x3", dbg_data, 32'd0);

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we = ($urandom_range(0, 3) != 0);
      ra = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ra = 5'd0;
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      ad = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      drive(we, ra, wd, a1, a2, ad);
      e1 = (a1 == 0) ? 32'd0 : ((we && ra == a1) ? wd : model[a1]);
      e2 = (a2 == 0) ? 32'd0 : ((we && ra == a2) ? wd : model[a2]);
      #1;
      check($sformatf("rnd%0d rs1 x%0d", n, a1), rs1_data, e1);
      check($sformatf("rnd%0d rs2 x%0d", n, a2), rs2_data, e2);
      check($sformatf("rnd%0d dbg x%0d", n, ad), dbg_data, model[ad]);
      if (we && ra != 0) model[ra] = wd;
    end

    // Reset dropped during a pending write to x9: the write is lost.
    write_reg(5'd9, 32'd77);
    idle();
    dbg_addr = 5'd9;
    #1;
    check("x9 before midrst", dbg_data, 32'd77);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd0, 5'd9);
    #10;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reg_write = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("midrst dbg x9", dbg_data, 32'd0);
    check("midrst rs1 x9", rs1_data, 32'd0);
    @(posedge clk);
    #1;
    check("midrst x9 next", dbg_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
